// File: rtl/trap_sequencer_if.sv
// CSR traffic for the trap sequencer: pipeline CSR write requests in,
// and the single architectural CSR write port out.
interface trap_sequencer_if;
  logic        csr_req_valid_i;
  logic [11:0] csr_req_addr_i;
  logic [31:0] csr_req_data_i;
  logic        csr_req_ready_o;
  logic        csr_w_en_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_w_data_o;

  modport slave (
    input  csr_req_valid_i, csr_req_addr_i, csr_req_data_i,
    output csr_req_ready_o, csr_w_en_o, csr_addr_o, csr_w_data_o
  );

  modport master (
    output csr_req_valid_i, csr_req_addr_i, csr_req_data_i,
    input  csr_req_ready_o, csr_w_en_o, csr_addr_o, csr_w_data_o
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: serialises the mepc/mcause/mtval/mstatus
// updates over one CSR write port, then redirects fetch.
module trap_sequencer #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mip_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mtvec_base_i,
  input  logic [1:0]  mtvec_mode_i,
  trap_sequencer_if.slave csr,
  output logic        event_ack_o,
  output logic        busy_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS, REDIRECT
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q, cause_q, tval_q, redirect_pc_q;
  logic        irq_q;

  logic        idle, irq_take, take_exc, take_irq, take_mret, accept;
  logic [31:0] irq_pend, status_trap, status_mret, trap_target;
  logic [4:0]  irq_code;

  assign idle      = (state_q == IDLE);
  assign irq_pend  = mip_i & mie_i & 32'h0000_0888;
  assign irq_take  = mstatus_i[3] & (|irq_pend);
  assign irq_code  = irq_pend[11] ? 5'd11 : (irq_pend[3] ? 5'd3 : 5'd7);

  assign take_exc  = idle & exc_valid_i;
  assign take_irq  = idle & ~exc_valid_i & irq_take;
  assign take_mret = idle & ~exc_valid_i & ~irq_take & mret_i;
  assign accept    = take_exc | take_irq | take_mret;

  // Trap entry: MPIE<=MIE, MIE<=0, MPP<=M. mret: MIE<=MPIE, MPIE<=1, MPP<=M.
  always_comb begin
    status_trap        = mstatus_i;
    status_trap[7]     = mstatus_i[3];
    status_trap[3]     = 1'b0;
    status_trap[12:11] = 2'b11;
    status_mret        = mstatus_i;
    status_mret[3]     = mstatus_i[7];
    status_mret[7]     = 1'b1;
    status_mret[12:11] = 2'b11;
  end

  assign trap_target = (VECTORED_EN && mtvec_mode_i == 2'b01 && irq_q)
                     ? mtvec_base_i + {25'b0, cause_q[4:0], 2'b00}
                     : mtvec_base_i;

  // Outputs are gated by reset so an aborted sequence emits nothing more.
  assign event_ack_o         = ~reset & accept;
  assign flush_o             = ~reset & accept;
  assign busy_o              = ~reset & ~idle;
  assign redirect_valid_o    = ~reset & (state_q == REDIRECT);
  assign redirect_pc_o       = redirect_pc_q;
  assign csr.csr_req_ready_o = ~reset & idle & ~accept;

  always_comb begin
    csr.csr_w_en_o   = 1'b0;
    csr.csr_addr_o   = 12'h000;
    csr.csr_w_data_o = 32'h0;
    if (!reset) begin
      case (state_q)
        IDLE: if (csr.csr_req_valid_i && !accept) begin
          csr.csr_w_en_o   = 1'b1;
          csr.csr_addr_o   = csr.csr_req_addr_i;
          csr.csr_w_data_o = csr.csr_req_data_i;
        end
        W_EPC: begin
          csr.csr_w_en_o   = 1'b1;
          csr.csr_addr_o   = 12'h341;
          csr.csr_w_data_o = pc_q & ~32'h1;
        end
        W_CAUSE: begin
          csr.csr_w_en_o   = 1'b1;
          csr.csr_addr_o   = 12'h342;
          csr.csr_w_data_o = cause_q;
        end
        W_TVAL: begin
          csr.csr_w_en_o   = 1'b1;
          csr.csr_addr_o   = 12'h343;
          csr.csr_w_data_o = tval_q;
        end
        W_STATUS: begin
          csr.csr_w_en_o   = 1'b1;
          csr.csr_addr_o   = 12'h300;
          csr.csr_w_data_o = status_trap;
        end
        M_STATUS: begin
          csr.csr_w_en_o   = 1'b1;
          csr.csr_addr_o   = 12'h300;
          csr.csr_w_data_o = status_mret;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= 32'h0;
      cause_q       <= 32'h0;
      tval_q        <= 32'h0;
      irq_q         <= 1'b0;
      redirect_pc_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_exc) begin
            pc_q    <= trap_pc_i;
            cause_q <= exc_cause_i;
            tval_q  <= exc_tval_i;
            irq_q   <= 1'b0;
            state_q <= W_EPC;
          end else if (take_irq) begin
            pc_q    <= trap_pc_i;
            cause_q <= {1'b1, 26'b0, irq_code};
            tval_q  <= 32'h0;
            irq_q   <= 1'b1;
            state_q <= W_EPC;
          end else if (take_mret) begin
            state_q <= M_STATUS;
          end
        end
        W_EPC:    state_q <= W_CAUSE;
        W_CAUSE:  state_q <= W_TVAL;
        W_TVAL:   state_q <= W_STATUS;
        W_STATUS: begin
          redirect_pc_q <= trap_target;
          state_q       <= REDIRECT;
        end
        M_STATUS: begin
          redirect_pc_q <= mepc_i & ~32'h1;
          state_q       <= REDIRECT;
        end
        REDIRECT: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench: the driver predicts every CSR write and redirect (with
// its cycle) from the architectural rules; a negedge monitor pops and compares.
module tb_trap_sequencer;
  localparam bit VEC = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid_i, mret_i;
  logic [31:0] exc_cause_i, trap_pc_i, exc_tval_i;
  logic [31:0] mstatus_i, mip_i, mie_i, mepc_i, mtvec_base_i;
  logic [1:0]  mtvec_mode_i;
  logic        event_ack_o, busy_o, flush_o, redirect_valid_o;
  logic [31:0] redirect_pc_o;

  trap_sequencer_if csr_if();

  trap_sequencer #(.VECTORED_EN(VEC)) dut (
    .clk(clk), .reset(reset),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .trap_pc_i(trap_pc_i),
    .exc_tval_i(exc_tval_i), .mret_i(mret_i),
    .mstatus_i(mstatus_i), .mip_i(mip_i), .mie_i(mie_i), .mepc_i(mepc_i),
    .mtvec_base_i(mtvec_base_i), .mtvec_mode_i(mtvec_mode_i),
    .csr(csr_if),
    .event_ack_o(event_ack_o), .busy_o(busy_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_redir;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit r, input logic [11:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.is_redir = r; e.addr = a; e.data = d; e.cyc = c;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] ms_trap(input logic [31:0] m);
    return (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] ms_mret(input logic [31:0] m);
    return (m & ~32'h0000_1888) | 32'h0000_1880 | (m[7] ? 32'h8 : 32'h0);
  endfunction

  // Monitor: every write-port or redirect event must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (csr_if.csr_w_en_o || redirect_valid_o) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", {30'b0, csr_if.csr_w_en_o, redirect_valid_o}, 32'h0);
        end else begin
          mon_e = sbq.pop_front();
          chk("out_kind", {31'b0, redirect_valid_o}, {31'b0, mon_e.is_redir});
          chk("out_cycle", cyc, mon_e.cyc);
          if (mon_e.is_redir) chk("redirect_pc", redirect_pc_o, mon_e.data);
          else begin
            chk("csr_addr", {20'b0, csr_if.csr_addr_o}, {20'b0, mon_e.addr});
            chk("csr_data", csr_if.csr_w_data_o, mon_e.data);
          end
        end
      end else begin
        chk("idle_addr_zero", {20'b0, csr_if.csr_addr_o}, 32'h0);
        chk("idle_data_zero", csr_if.csr_w_data_o, 32'h0);
      end
    end
  end

  task automatic clear_events();
    exc_valid_i = 1'b0; mret_i = 1'b0; mip_i = 32'h0;
    csr_if.csr_req_valid_i = 1'b0;
  endtask

  // Apply one IDLE-cycle stimulus, predict its full outcome, and walk it to IDLE.
  task automatic do_txn(input logic ev, input logic [31:0] ecause, pc, tval,
                        input logic mr, input logic [31:0] mst, mip, mie, mepc, base,
                        input logic [1:0] mode, input logic rv,
                        input logic [11:0] ra, input logic [31:0] rd);
    int n, kind, lat, code;
    logic [31:0] pend, tgt;
    exc_valid_i = ev; exc_cause_i = ecause; trap_pc_i = pc; exc_tval_i = tval;
    mret_i = mr; mstatus_i = mst; mip_i = mip; mie_i = mie; mepc_i = mepc;
    mtvec_base_i = base; mtvec_mode_i = mode;
    csr_if.csr_req_valid_i = rv; csr_if.csr_req_addr_i = ra; csr_if.csr_req_data_i = rd;
    n    = cyc;
    pend = mip & mie & 32'h888;
    code = pend[11] ? 11 : (pend[3] ? 3 : 7);
    if (ev) kind = 1;
    else if (mst[3] && pend != 0) kind = 2;
    else if (mr) kind = 3;
    else kind = 0;
    case (kind)
      1, 2: begin
        push(0, 12'h341, pc & ~32'h1, n + 1);
        push(0, 12'h342, (kind == 1) ? ecause : (32'h8000_0000 | 32'(code)), n + 2);
        push(0, 12'h343, (kind == 1) ? tval : 32'h0, n + 3);
        push(0, 12'h300, ms_trap(mst), n + 4);
        tgt = (kind == 2 && VEC && mode == 2'b01) ? base + 32'(4 * code) : base;
        push(1, 12'h0, tgt, n + 5);
      end
      3: begin
        push(0, 12'h300, ms_mret(mst), n + 1);
        push(1, 12'h0, mepc & ~32'h1, n + 2);
      end
      default: if (rv) push(0, ra, rd, n);
    endcase
    lat = (kind == 0) ? 1 : ((kind == 3) ? 3 : 6);
    @(negedge clk);
    chk("event_ack", {31'b0, event_ack_o}, {31'b0, kind != 0});
    chk("flush", {31'b0, flush_o}, {31'b0, kind != 0});
    chk("req_ready", {31'b0, csr_if.csr_req_ready_o}, {31'b0, kind == 0});
    chk("busy_at_accept", {31'b0, busy_o}, 32'h0);
    @(posedge clk); #1;
    for (int i = 1; i < lat; i++) begin
      // Event inputs are noise while busy and must be ignored.
      exc_valid_i = 1'($urandom); mret_i = 1'($urandom);
      trap_pc_i = $urandom; exc_cause_i = $urandom; exc_tval_i = $urandom;
      mip_i = 32'h0;
      @(negedge clk);
      chk("busy", {31'b0, busy_o}, 32'h1);
      chk("ready_while_busy", {31'b0, csr_if.csr_req_ready_o}, 32'h0);
      chk("no_ack_while_busy", {31'b0, event_ack_o}, 32'h0);
      @(posedge clk); #1;
    end
    if (kind != 0 && rv) begin
      clear_events();
      csr_if.csr_req_valid_i = 1'b1;
      push(0, ra, rd, n + lat);
      @(negedge clk);
      chk("held_req_ready", {31'b0, csr_if.csr_req_ready_o}, 32'h1);
      @(posedge clk); #1;
    end
    clear_events();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_events();
    exc_cause_i = 0; trap_pc_i = 0; exc_tval_i = 0; mstatus_i = 0; mie_i = 0;
    mepc_i = 0; mtvec_base_i = 0; mtvec_mode_i = 0;
    csr_if.csr_req_addr_i = 0; csr_if.csr_req_data_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_w_en", {31'b0, csr_if.csr_w_en_o}, 32'h0);
    chk("rst_ack", {31'b0, event_ack_o}, 32'h0);
    chk("rst_flush", {31'b0, flush_o}, 32'h0);
    chk("rst_redir_valid", {31'b0, redirect_valid_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_redir_pc", redirect_pc_o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Exception with known values, then a vectored MEI.
    do_txn(1, 32'd2, 32'h100, 32'hDEAD, 0, 32'h8, 0, 0, 0, 32'h4000, 2'b00, 0, 0, 0);
    do_txn(0, 0, 32'h204, 0, 0, 32'h8, 32'h888, 32'h888, 0, 32'h2000, 2'b01, 0, 0, 0);
    // Exception, interrupt, mret and a CSR request all at once.
    do_txn(1, 32'd5, 32'h333, 32'h77, 1, 32'h8, 32'h888, 32'h888, 32'h50, 32'h1000, 2'b01,
           1, 12'h7C0, 32'hCAFE_F00D);
    // mret, then back-to-back MTI (vectored, wraps near top of address space).
    do_txn(0, 0, 0, 0, 1, 32'h1880, 0, 0, 32'h305, 32'h0, 2'b00, 0, 0, 0);
    do_txn(0, 0, 32'h40, 0, 0, 32'h8, 32'h80, 32'h80, 0, 32'hFFFF_FFF0, 2'b01, 0, 0, 0);
    // Plain CSR write while idle.
    do_txn(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 1, 12'h305, 32'h1234_5678);

    // Reset landing on W_CAUSE aborts the remaining writes and the redirect.
    begin
      int n;
      exc_valid_i = 1'b1; exc_cause_i = 32'd7; trap_pc_i = 32'h880; exc_tval_i = 32'h99;
      mstatus_i = 32'h8; mtvec_base_i = 32'h600; mtvec_mode_i = 2'b00;
      n = cyc;
      push(0, 12'h341, 32'h880, n + 1);
      @(posedge clk); #1;
      clear_events();
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_w_en", {31'b0, csr_if.csr_w_en_o}, 32'h0);
      chk("abort_redir", {31'b0, redirect_valid_o}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_idle", {31'b0, busy_o}, 32'h0);
      chk("abort_redir_pc", redirect_pc_o, 32'h0);
      chk("abort_sb_empty", sbq.size(), 0);
      @(posedge clk); #1;
    end

    for (int t = 0; t < 300; t++) begin
      do_txn(($urandom % 4) == 0, $urandom, $urandom, $urandom, ($urandom % 3) == 0,
             $urandom, $urandom & 32'h0000_0888, $urandom, $urandom,
             $urandom & ~32'h3, 2'($urandom), 1'($urandom), 12'($urandom), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter VECTORED_EN, default 1, meaning vectored mtvec mode (mode 2'b01) is honoured; when 0, all traps go to base.
REQ-002 SHALL have ports clk  in  1  system clock (rising edge); reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have trap inputs exc_valid_i  in  1  exception request; exc_cause_i  in  32  exception cause; trap_pc_i  in  32  faulting/next PC; exc_tval_i  in  32  trap value; mret_i  in  1  mret request.
REQ-004 SHALL have CSR-state inputs mstatus_i  in  32; mip_i  in  32; mie_i  in  32; mepc_i  in  32; mtvec_base_i  in  32 (word aligned); mtvec_mode_i  in  2.
REQ-005 SHALL have pipeline CSR write inputs csr_req_valid_i  in  1; csr_req_addr_i  in  12; csr_req_data_i  in  32; and output csr_req_ready_o  out  1.
REQ-006 SHALL have CSR write-port outputs csr_w_en_o  out  1; csr_addr_o  out  12; csr_w_data_o  out  32.
REQ-007 SHALL have control outputs event_ack_o  out  1; busy_o  out  1; flush_o  out  1; redirect_valid_o  out  1; redirect_pc_o  out  32.

Function
REQ-008 SHALL implement states IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS, REDIRECT.
REQ-009 In IDLE, event priority SHALL be: exc_valid_i > enabled interrupt > mret_i; only the winner is accepted; losers are not acked.
REQ-010 Enabled interrupt = mstatus_i[3] (MIE) & |(mip_i & mie_i & mask bits 11,3,7); selection priority MEI(11) > MSI(3) > MTI(7).
REQ-011 On acceptance, event_ack_o and flush_o SHALL pulse for exactly that cycle; trap_pc_i, cause and tval SHALL be latched internally.
REQ-012 Latched cause: exception -> exc_cause_i; interrupt -> {1'b1, 26'b0, code[4:0]}; latched tval: exception -> exc_tval_i, interrupt -> 0.
REQ-013 Trap path: IDLE -> W_EPC -> W_CAUSE -> W_TVAL -> W_STATUS -> REDIRECT -> IDLE, one state per cycle.
REQ-014 W_EPC writes 0x341 = {pc[31:1],0}; W_CAUSE writes 0x342; W_TVAL writes 0x343; W_STATUS writes 0x300 = mstatus_i with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
REQ-015 mret path: IDLE -> M_STATUS -> REDIRECT -> IDLE; M_STATUS writes 0x300 = mstatus_i with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
REQ-016 In REDIRECT, redirect_valid_o SHALL pulse one cycle; no CSR write occurs.
REQ-017 Trap redirect_pc_o = base, except VECTORED_EN=1 & mode=2'b01 & interrupt -> base + 4*code (32-bit, wraps modulo 2^32); mret -> mepc_i & ~1.
REQ-018 redirect_pc_o SHALL hold its last value outside REDIRECT; only redirect_valid_o qualifies it.
REQ-019 csr_w_en_o SHALL be 1 in every W_*/M_STATUS state, and otherwise only for a granted pipeline request.
REQ-020 csr_req_ready_o = (state==IDLE) & no event accepted that cycle; grant writes csr_req_addr_i/csr_req_data_i combinationally the same cycle.
REQ-021 busy_o SHALL be 1 in every state except IDLE; all trap/mret inputs are ignored while busy.
REQ-022 Latency: trap accepted at cycle N -> redirect_valid_o at N+5; mret at N -> N+2; back-to-back events are accepted at earliest N+6 / N+3.
REQ-023 Unused write-port outputs (addr, data) SHALL be 0 when csr_w_en_o=0.

Reset
REQ-024 On reset, state SHALL go to IDLE and latches SHALL clear to 0; csr_w_en_o, event_ack_o, flush_o, redirect_valid_o, busy_o SHALL be 0 and redirect_pc_o 0.
REQ-025 Reset asserted mid-sequence SHALL abort immediately: no further CSR write or redirect from the aborted event.

Verification
REQ-026 exc_valid_i=1, cause=2, pc=0x100, tval=0xDEAD, mstatus=0x8 -> writes 0x341=0x100, 0x342=2, 0x343=0xDEAD, 0x300=0x1880 on N+1..N+4; redirect to base at N+5.
REQ-027 MIE=1, mip=mie=0x888, mtvec base 0x2000 mode 01 -> cause 0x8000000B, redirect 0x202C.
REQ-028 exc_valid_i, interrupt and mret all in one cycle -> exception taken; mret not acked; csr_req_ready_o=0 that cycle.
REQ-029 mret with mstatus=0x1880, mepc=0x305 -> 0x300=0x1888 at N+1, redirect 0x304 at N+2.
REQ-030 csr_req_valid_i held during trap sequence -> ready=0 for N..N+5, granted at N+6; reset at W_CAUSE -> no 0x342/0x343/0x300 writes, IDLE next cycle.
